// File: rtl/pseudo_ana_stk_n_if.sv
// Button/frame inputs and pseudo-analog axis outputs of pseudo_ana_stk_n.
// The master drives buttons and PV; the slave (the stick block) drives AX/ACTIVE.
interface pseudo_ana_stk_n_if #(
  parameter int CHANNELS = 2,
  parameter int W        = 8
);
  logic [8:0]            pv;
  logic [CHANNELS-1:0]   neg;
  logic [CHANNELS-1:0]   pos;
  logic                  spring;
  logic                  recenter;
  logic [CHANNELS*W-1:0] ax;
  logic [CHANNELS-1:0]   active;

  modport master (
    output pv, neg, pos, spring, recenter,
    input  ax, active
  );

  modport slave (
    input  pv, neg, pos, spring, recenter,
    output ax, active
  );
endinterface

// File: rtl/pseudo_ana_stk_n.sv
// Digital buttons to per-axis pseudo-analog position, updated once per video frame.
// Zero added latency: AX/ACTIVE are combinational from the registered positions.
module pseudo_ana_stk_n #(
  parameter int CHANNELS = 2,
  parameter int W        = 8,
  parameter int DMIN     = 8,
  parameter int DINC     = 4,
  parameter int DMAX     = 24,
  parameter int LIMIT    = 120
) (
  input logic              clk_i,
  input logic              rst_i,
  pseudo_ana_stk_n_if.slave bus
);

  localparam int PW = W + 2;
  localparam int XW = W + 4;

  localparam logic [W-1:0]          CTR   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]          S_MIN = W'(DMIN);
  localparam logic [W-1:0]          S_MAX = W'(DMAX);
  localparam logic signed [XW-1:0]  X_MIN = XW'(DMIN);
  localparam logic signed [XW-1:0]  X_LIM = XW'(LIMIT);

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_POS  = 2'd1,
    DIR_NEG  = 2'd2
  } dir_e;

  logic [8:0] ppv_q;
  logic       tick;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ppv_q <= '0;
    else       ppv_q <= bus.pv;
  end

  // Falling into line 0 from any other line marks the start of a frame.
  assign tick = (bus.pv == 9'd0) && (ppv_q != 9'd0);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_axis
    logic signed [PW-1:0] p_q, p_d;
    logic [W-1:0]         s_q, s_d;
    dir_e                 d_q, d_d;
    dir_e                 held;
    logic [W-1:0]         step;
    logic [W:0]           s_inc;
    logic signed [XW-1:0] p_x, step_x, nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        p_q <= '0;
        s_q <= S_MIN;
        d_q <= DIR_NONE;
      end else begin
        p_q <= p_d;
        s_q <= s_d;
        d_q <= d_d;
      end
    end

    always_comb begin
      held = DIR_NONE;
      if (bus.pos[i] && !bus.neg[i])      held = DIR_POS;
      else if (bus.neg[i] && !bus.pos[i]) held = DIR_NEG;

      // A new press or reversal restarts the ramp at the minimum step.
      step   = (held == d_q) ? s_q : S_MIN;
      s_inc  = {1'b0, step} + (W+1)'(DINC);
      p_x    = {{(XW-PW){p_q[PW-1]}}, p_q};
      step_x = {{(XW-W){1'b0}}, step};
      nxt    = p_x;

      p_d = p_q;
      s_d = s_q;
      d_d = d_q;

      if (bus.recenter) begin
        p_d = '0;
        s_d = S_MIN;
        d_d = DIR_NONE;
      end else if (tick) begin
        d_d = held;
        case (held)
          DIR_POS: nxt = p_x + step_x;
          DIR_NEG: nxt = p_x - step_x;
          default: begin
            if (bus.spring) begin
              if (p_x > X_MIN)       nxt = p_x - X_MIN;
              else if (p_x < -X_MIN) nxt = p_x + X_MIN;
              else                   nxt = '0;
            end
          end
        endcase

        if (held == DIR_NONE)        s_d = S_MIN;
        else if (s_inc > {1'b0, S_MAX}) s_d = S_MAX;
        else                         s_d = s_inc[W-1:0];

        // The extended width keeps the pre-clamp sum from wrapping.
        if (nxt > X_LIM)       nxt = X_LIM;
        else if (nxt < -X_LIM) nxt = -X_LIM;
        p_d = nxt[PW-1:0];
      end
    end

    assign bus.ax[i*W +: W] = p_q[W-1:0] + CTR;
    assign bus.active[i]    = (p_q != '0);
  end

endmodule

// File: tb/tb_pseudo_ana_stk_n.sv
// Directed and randomized checks of pseudo_ana_stk_n against an arithmetic model.
module tb_pseudo_ana_stk_n;
  localparam int CH = 2, W = 8, DMIN = 8, DINC = 4, DMAX = 24, LIMIT = 120;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pseudo_ana_stk_n_if #(.CHANNELS(CH), .W(W)) bus ();

  pseudo_ana_stk_n #(
    .CHANNELS(CH), .W(W), .DMIN(DMIN), .DINC(DINC), .DMAX(DMAX), .LIMIT(LIMIT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: position, step, last direction (-1/0/+1) per axis, previous PV.
  int mp[CH];
  int ms[CH];
  int md[CH];
  int mppv;

  int r35[7] = '{135, 147, 163, 183, 207, 231, 247};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset_axes();
    for (int i = 0; i < CH; i++) begin
      mp[i] = 0;
      ms[i] = DMIN;
      md[i] = 0;
    end
  endtask

  task automatic model_edge();
    int tk, dir, step;
    if (rst) return;
    tk   = (bus.pv == 0 && mppv != 0);
    mppv = int'(bus.pv);
    if (bus.recenter) begin
      model_reset_axes();
    end else if (tk != 0) begin
      for (int i = 0; i < CH; i++) begin
        dir = (bus.pos[i] && !bus.neg[i]) ? 1 : (bus.neg[i] && !bus.pos[i]) ? -1 : 0;
        if (dir == 0) begin
          ms[i] = DMIN;
          if (bus.spring) begin
            if (mp[i] <= DMIN && mp[i] >= -DMIN) mp[i] = 0;
            else mp[i] = mp[i] + ((mp[i] > 0) ? -DMIN : DMIN);
          end
        end else begin
          step  = (dir == md[i]) ? ms[i] : DMIN;
          mp[i] = mp[i] + dir * step;
          ms[i] = (step + DINC > DMAX) ? DMAX : step + DINC;
        end
        if (mp[i] > LIMIT)  mp[i] = LIMIT;
        if (mp[i] < -LIMIT) mp[i] = -LIMIT;
        md[i] = dir;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] eax, eact;
    eax  = '0;
    eact = '0;
    for (int i = 0; i < CH; i++) begin
      eax  = eax | (32'((mp[i] + 127) & 255) << (i * W));
      eact = eact | (32'(mp[i] != 0) << i);
    end
    chk({tag, ".ax"}, 32'(bus.ax), eax);
    chk({tag, ".active"}, 32'(bus.active), eact);
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic frame(input string tag);
    bus.pv = 9'd1;
    cyc(tag);
    bus.pv = 9'd0;
    cyc(tag);
  endtask

  initial begin
    rst          = 1'b1;
    bus.pv       = '0;
    bus.pos      = '0;
    bus.neg      = '0;
    bus.spring   = 1'b1;
    bus.recenter = 1'b0;
    mppv         = 0;
    model_reset_axes();
    #2;
    chk("reset.ax", 32'(bus.ax), 32'h7F7F);
    chk("reset.active", 32'(bus.active), 0);
    cyc("reset");
    rst = 1'b0;

    // PV resting at 0 straight out of reset is not a frame start.
    bus.pos = 2'b01;
    for (int k = 0; k < 3; k++) begin
      cyc("first_pv0");
      chk("first_pv0.ax0", 32'(bus.ax[7:0]), 127);
    end

    for (int k = 0; k < 7; k++) begin
      frame("ramp");
      chk("ramp.ax0", 32'(bus.ax[7:0]), 32'(r35[k]));
      chk("ramp.ax1", 32'(bus.ax[15:8]), 127);
    end

    bus.pos = 2'b00;
    for (int k = 1; k <= 15; k++) begin
      frame("spring");
      chk("spring.ax0", 32'(bus.ax[7:0]), (k < 15) ? 32'(247 - 8 * k) : 32'd127);
      chk("spring.act0", 32'(bus.active[0]), (k < 15) ? 32'd1 : 32'd0);
    end

    bus.pos = 2'b01;
    for (int k = 0; k < 3; k++) frame("to36");
    chk("to36.ax0", 32'(bus.ax[7:0]), 163);
    bus.pos = 2'b00;
    bus.neg = 2'b01;
    frame("reverse");
    chk("reverse1.ax0", 32'(bus.ax[7:0]), 155);
    frame("reverse");
    chk("reverse2.ax0", 32'(bus.ax[7:0]), 143);

    bus.neg      = 2'b00;
    bus.recenter = 1'b1;
    cyc("recenter");
    bus.recenter = 1'b0;
    bus.spring   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.neg = 2'b01;
      frame("to_m40");
      bus.neg = 2'b00;
      frame("to_m40");
    end
    chk("m40.ax0", 32'(bus.ax[7:0]), 87);
    bus.pos = 2'b01;
    bus.neg = 2'b01;
    for (int k = 0; k < 2; k++) begin
      frame("both");
      chk("both.ax0", 32'(bus.ax[7:0]), 87);
    end

    bus.neg    = 2'b00;
    bus.pv     = 9'd1;
    cyc("rc_tick");
    bus.pv       = 9'd0;
    bus.recenter = 1'b1;
    cyc("rc_tick");
    chk("rc_tick.ax", 32'(bus.ax), 32'h7F7F);
    bus.recenter = 1'b0;
    frame("after_rc");
    chk("after_rc.ax0", 32'(bus.ax[7:0]), 135);

    for (int k = 0; k < 3; k++) frame("preramp");
    #2;
    rst = 1'b1;
    model_reset_axes();
    mppv = 0;
    #1;
    chk("midreset.ax", 32'(bus.ax), 32'h7F7F);
    cyc("midreset");
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc("post_reset_pv0");
      chk("post_reset_pv0.ax0", 32'(bus.ax[7:0]), 127);
    end
    frame("post_reset_tick");
    chk("post_reset_tick.ax0", 32'(bus.ax[7:0]), 135);
    for (int k = 0; k < 2; k++) begin
      cyc("post_reset_hold");
      chk("post_reset_hold.ax0", 32'(bus.ax[7:0]), 135);
    end

    for (int k = 0; k < 600; k++) begin
      bus.pv       = ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
      bus.pos      = 2'($urandom_range(0, 3));
      bus.neg      = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) bus.spring = ~bus.spring;
      bus.recenter = ($urandom_range(0, 29) == 0);
      cyc("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pseudo_ana_stk_n.md
PSEUDO_ANA_STK_N -- requirements
Module: pseudo_ana_stk_n

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent pseudo-analog axes.
REQ-002 Parameter W, default 8: output width per axis.
REQ-003 Parameter DMIN, default 8: initial per-frame step and spring return step.
REQ-004 Parameter DINC, default 4: step increment per consecutive held frame.
REQ-005 Parameter DMAX, default 24: maximum step.
REQ-006 Parameter LIMIT, default 120: position magnitude clamp, legal range 1..2^(W-1)-1.
REQ-007 CLK  in  1: single system clock; every register is clocked by it.
REQ-008 RESET  in  1: asynchronous, active-high reset.
REQ-009 PV  in  9: vertical position; a frame tick is the cycle where PV==0 and the previous sampled PV!=0.
REQ-010 NEG  in  CHANNELS: per-axis negative-direction button, bit i = axis i.
REQ-011 POS  in  CHANNELS: per-axis positive-direction button.
REQ-012 SPRING  in  1: 1 = released axes return to center, 0 = released axes hold position.
REQ-013 RECENTER  in  1: synchronous command that forces every axis to center.
REQ-014 AX  out  CHANNELS*W: axis i at bits [i*W+W-1 : i*W], unsigned, center 2^(W-1)-1.
REQ-015 ACTIVE  out  CHANNELS: bit i = 1 when axis i position is nonzero.

Function
REQ-016 Per axis, hold signed position p (W+2 bits), step register s, and last-direction register d (none/pos/neg); previous-PV register pPV (9 bits).
REQ-017 pPV samples PV on every clock edge.
REQ-018 State updates only on the clock edge of a frame tick or while RECENTER=1; otherwise all state holds.
REQ-019 Held direction on a tick: POS only = pos; NEG only = neg; both or neither = none.
REQ-020 Held direction equal to d: p += s (pos) or p -= s (neg), then s = min(s+DINC, DMAX).
REQ-021 Held direction differing from d (new press or reversal): move by DMIN, then s = min(DMIN+DINC, DMAX).
REQ-022 Direction none with SPRING=1: if |p| <= DMIN, p = 0; otherwise p moves toward 0 by DMIN. s = DMIN.
REQ-023 Direction none with SPRING=0: p unchanged. s = DMIN.
REQ-024 d takes the held direction (including none) on every tick.
REQ-025 After stepping, p clamps to [-LIMIT, +LIMIT] in the same edge; the intermediate sum never wraps.
REQ-026 AX slice i = p_i + (2^(W-1)-1), combinational from registered p, so it changes on the updating edge (zero added latency).
REQ-027 ACTIVE bit i = (p_i != 0), combinational.
REQ-028 RECENTER=1 on any edge: every p = 0, s = DMIN, d = none; this takes priority over a simultaneous tick.
REQ-029 Axes are fully independent; one axis's inputs never affect another axis.
REQ-030 PV held at 0 across consecutive cycles produces one tick only; PV staying nonzero produces no tick.

Reset
REQ-031 RESET=1 asynchronously sets every p = 0, s = DMIN, d = none, pPV = 0.
REQ-032 During and after reset: AX = all slices 2^(W-1)-1 (127 at W=8), ACTIVE = 0.
REQ-033 Reset asserted mid-ramp discards all ramp state; the first tick after release behaves as a fresh press.
REQ-034 The first PV==0 after reset, with pPV==0, is not a tick.

Verification (defaults, CHANNELS=2, W=8)
REQ-035 POS[0] held for 7 ticks -> AX[7:0] = 135, 147, 163, 183, 207, 231, 247 (clamped at 120); AX[15:8] = 127 throughout.
REQ-036 From p=120, release with SPRING=1 -> 112, 104, ... , 8, then 0 (AX 239 ... 135, 127); ACTIVE[0] falls on the tick where p reaches 0.
REQ-037 From p=36 (s=20), reverse to NEG -> p = 28 (step DMIN), next tick p = 16 (step 12).
REQ-038 POS and NEG both held with SPRING=0 at p=-40 -> p stays -40, AX = 87.
REQ-039 RECENTER asserted in the same cycle as a tick, with POS held -> all AX = 127; the next tick moves p by 8.
REQ-040 RESET pulsed mid-ramp, then PV held at 0 for 5 cycles followed by one 0->1->0 cycle -> AX stays 127 until the first true tick; exactly one update of +8.
